// File: rtl/mem_arbiter.sv
// Purpose : two-requester (data stage, fetch) round-robin arbiter onto one shared memory port.
// Latency : ready pulses 2+WAIT_CYCLES cycles after a request is seen in IDLE (mem_ready high).
// Backpr. : mem_ready low stretches ACCESS indefinitely; requesters hold their request until ready.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   d_read/d_write/d_addr/d_wdata    data-stage request; d_rdata/d_ready its result and completion pulse
//   f_read/f_addr                    fetch (read-only) request; f_rdata/f_ready its result and pulse
//   mem_*                            shared memory port; mem_read_data is combinational from mem_address
//
// WAIT_CYCLES is legal in 0..15 (the wait counter is 4 bits).
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              f_read,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_f_q, gnt_f_d;    // 1: fetch owns the current access
  logic              last_f_q, last_f_d;  // 1: fetch was granted last
  logic              wr_q, wr_d;          // current access is a write
  logic              rdz_q, rdz_d;        // read+write collided: d_rdata returns 0
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;

  logic d_req;
  logic pick_f;
  logic in_access;
  logic last_cycle;

  always_comb begin
    d_req      = d_read | d_write;
    // Fetch wins when it is alone, or on a tie when the data stage was granted last.
    pick_f     = f_read & (~d_req | ~last_f_q);
    in_access  = (state_q == ACCESS);
    last_cycle = in_access & (cnt_q == 4'd0) & mem_ready;

    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_f_d   = gnt_f_q;
    last_f_d  = last_f_q;
    wr_d      = wr_q;
    rdz_d     = rdz_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    d_rdata_d = d_rdata_q;
    f_rdata_d = f_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req | f_read) begin
          state_d  = ACCESS;
          cnt_d    = WAIT_LOAD;
          gnt_f_d  = pick_f;
          last_f_d = pick_f;
          addr_d   = pick_f ? f_addr : d_addr;
          wr_d     = ~pick_f & d_write;
          rdz_d    = ~pick_f & d_write & d_read;
          wdata_d  = (~pick_f & d_write) ? d_wdata : '0;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (last_cycle) begin
          state_d = DONE;
          if (!wr_q) begin
            if (gnt_f_q) begin
              f_rdata_d = mem_read_data;
            end else begin
              d_rdata_d = mem_read_data;
            end
          end else if (rdz_q) begin
            d_rdata_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_f_q   <= 1'b0;
      last_f_q  <= 1'b1;  // data stage wins the first tie
      wr_q      <= 1'b0;
      rdz_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      f_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_f_q   <= gnt_f_d;
      last_f_q  <= last_f_d;
      wr_q      <= wr_d;
      rdz_q     <= rdz_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      d_rdata_q <= d_rdata_d;
      f_rdata_q <= f_rdata_d;
    end
  end

  // Memory-side outputs are gated by state so they fall to 0 the moment reset hits.
  assign mem_address    = in_access ? addr_q : '0;
  assign mem_read       = in_access & ~wr_q;
  assign mem_write      = last_cycle & wr_q;
  assign mem_write_data = (in_access & wr_q) ? wdata_q : '0;

  assign d_ready = (state_q == DONE) & ~gnt_f_q;
  assign f_ready = (state_q == DONE) & gnt_f_q;
  assign d_rdata = d_rdata_q;
  assign f_rdata = f_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, default 32, address width.
- DATA_W, default 32, data word width.
- WAIT_CYCLES, default 2, extra access cycles before completion; legal range 0..15.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- d_read  in  1  data-stage read request.
- d_write  in  1  data-stage write request.
- d_addr  in  ADDR_W  data-stage byte address.
- d_wdata  in  DATA_W  data-stage write data.
- d_rdata  out  DATA_W  data-stage read result.
- d_ready  out  1  data-stage completion pulse.
- f_read  in  1  fetch read request (read-only requester).
- f_addr  in  ADDR_W  fetch byte address.
- f_rdata  out  DATA_W  fetch read result.
- f_ready  out  1  fetch completion pulse.
- mem_address  out  ADDR_W  shared memory address.
- mem_write_data  out  DATA_W  shared memory write data.
- mem_read  out  1  shared memory read enable.
- mem_write  out  1  shared memory write enable.
- mem_read_data  in  DATA_W  shared memory read data (combinational).
- mem_ready  in  1  shared memory ready.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.

REQ-004 In IDLE, the FSM SHALL move to ACCESS when any request is pending (d_read|d_write or f_read); otherwise it stays in IDLE.

REQ-005 Arbitration:
- A single requester SHALL win.
- On a tie, the requester not granted last SHALL win (round-robin).
- last_grant SHALL update on every grant.

REQ-006 On grant, the block SHALL latch requester id, address, write data (data stage only) and operation; the access then uses only the latched values.

REQ-007 If d_read and d_write are both high, the block SHALL perform a write, and d_rdata SHALL be 0 for that access.

REQ-008 On entering ACCESS, a 4-bit wait counter SHALL load WAIT_CYCLES and decrement by 1 per ACCESS cycle, saturating at 0.

REQ-009 ACCESS SHALL end when counter==0 and mem_ready==1; otherwise the FSM SHALL stay in ACCESS, so a mem_ready low stretches the access indefinitely.

REQ-010 During ACCESS:
- mem_address SHALL equal the latched address.
- mem_read SHALL be high for the whole of a read access.
- mem_write_data SHALL equal the latched data for a write.

REQ-011 mem_write SHALL be high only in the final ACCESS cycle (counter==0, mem_ready==1), giving exactly one write edge per write access.

REQ-012 Outside ACCESS, mem_read, mem_write, mem_address and mem_write_data SHALL be 0.

REQ-013 On the final ACCESS cycle of a read, mem_read_data SHALL be captured into the granted requester's rdata register.

REQ-014 In DONE, the granted requester's ready SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
- The non-granted requester's ready SHALL stay 0.
- rdata SHALL hold its value until the next capture for that requester.

REQ-015 Requester obligations and behaviour:
- Requesters hold request/address until their ready pulse.
- A request dropped mid-access SHALL NOT abort the access; the ready pulse is still issued.
- A request still high in the cycle after DONE SHALL be treated as a new request.

REQ-016 Latency: with a request seen in IDLE at cycle N and mem_ready held high, ready SHALL assert at cycle N+2+WAIT_CYCLES. The minimum is 2 cycles (WAIT_CYCLES=0).

REQ-017 Throughput SHALL be at most one access per 3+WAIT_CYCLES cycles; IDLE is always visited between accesses.

Reset
REQ-018 While rst is high, regardless of clk:
- state SHALL be IDLE.
- All outputs, rdata registers, latched address/data and the wait counter SHALL be 0.
- last_grant SHALL be fetch, so the data stage wins the first tie.

REQ-019 Reset asserted during ACCESS or DONE SHALL abort the access: no mem_write, no ready pulse, and rdata is cleared.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single fetch: WAIT_CYCLES=2, f_read=1, f_addr=0x400, mem_read_data=0x10000000 -> f_ready pulses at N+4 with f_rdata=0x10000000; d_ready stays 0.
- Tie: d_read and f_read both high from reset -> data stage served first, then fetch. Repeating the tie -> grants alternate D,F,D,F.
- Write pulse: d_write=1, d_addr=0x404, d_wdata=0xC0220000 -> mem_write high exactly 1 cycle with mem_address=0x404; d_ready one cycle later; d_rdata unchanged.
- Stall: mem_ready held 0 for 5 cycles in ACCESS -> mem_read stays high, no ready; completion 1 cycle after mem_ready rises.
- Reset mid-access: rst pulsed during a write's ACCESS -> mem_write never asserted; all outputs 0 immediately (asynchronous).
- Read+write both high with WAIT_CYCLES=0 -> write performed, d_rdata=0, d_ready at N+2.
